traffic_light_ctrl_p: RTL and testbench

Parametrised two-road (highway/farm) traffic light controller. It generalises the fixed four-phase highway/farm controller with:
- configurable tick prescaler and phase durations;
- a guaranteed minimum highway green;
- all-red clearance intervals;
- a latched pedestrian request with a walk output;
- a night flashing mode.

It sits directly behind the road sensors and drives the lamp drivers.

---
 rtl/traffic_light_ctrl_p.sv | 179 +++++++++++++++++
 tb/tb_traffic_light_ctrl_p.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl_p.sv
// Two-road highway/farm traffic light controller with prescaled phase timing,
// pedestrian walk service, all-red clearance and a night flashing mode.
module traffic_light_ctrl_p #(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 8,
    parameter int H_MIN    = 10,
    parameter int F_GREEN  = 10,
    parameter int YEL      = 3,
    parameter int ALL_RED  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       car_farm,
    input  logic       ped_req,
    input  logic       flash_mode,
    output logic [2:0] light_highway,
    output logic [2:0] light_farm,
    output logic       walk,
    output logic [2:0] phase
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]    PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] H_MIN_M1  = CNT_W'(H_MIN - 1);
    localparam logic [CNT_W-1:0] F_GRN_M1  = CNT_W'(F_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_M1    = CNT_W'(YEL - 1);
    localparam logic [CNT_W-1:0] AR_M1     = CNT_W'(ALL_RED - 1);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_D = 3'b000;

    typedef enum logic [2:0] {
        HG    = 3'd0,
        HY    = 3'd1,
        AR1   = 3'd2,
        FG    = 3'd3,
        FY    = 3'd4,
        AR2   = 3'd5,
        FLASH = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [PW-1:0]    presc;
    logic             tick;
    logic [CNT_W-1:0] timer;
    logic             ped_pending;
    logic             blink;
    logic             yel_done;
    logic             ar_done;
    logic             fg_done;
    logic             hg_req;
    logic             changing;

    assign tick     = (presc == PRESC_TOP);
    assign yel_done = tick && (timer == YEL_M1);
    assign ar_done  = tick && (timer == AR_M1);
    assign fg_done  = tick && (timer == F_GRN_M1);
    assign hg_req   = (timer >= H_MIN_M1) && (car_farm || ped_pending);
    assign changing = (state_nx != state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HG;
        end else begin
            state <= state_nx;
        end
    end

    // Timer restarts on every phase change and saturates rather than wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (changing) begin
            timer <= '0;
        end else if (tick && (timer != '1)) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pending <= 1'b0;
        end else if (state_nx == FG && state != FG) begin
            ped_pending <= 1'b0;
        end else if (ped_req) begin
            ped_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink <= 1'b0;
        end else if (state_nx == FLASH && state != FLASH) begin
            blink <= 1'b0;
        end else if (state == FLASH && tick) begin
            blink <= ~blink;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            HG: begin
                if (tick) begin
                    if (flash_mode) begin
                        state_nx = FLASH;
                    end else if (hg_req) begin
                        state_nx = HY;
                    end
                end
            end
            HY: begin
                if (yel_done) state_nx = AR1;
            end
            AR1: begin
                if (ar_done) state_nx = FG;
            end
            FG: begin
                if (fg_done) state_nx = FY;
            end
            FY: begin
                if (yel_done) state_nx = AR2;
            end
            AR2: begin
                if (ar_done) state_nx = HG;
            end
            FLASH: begin
                if (tick && !flash_mode) state_nx = AR2;
            end
            default: state_nx = AR2;
        endcase
    end

    // Lamps depend only on registered state and blink
    always_comb begin
        light_highway = LAMP_R;
        light_farm    = LAMP_R;
        walk          = 1'b0;
        phase         = state;
        case (state)
            HG: begin
                light_highway = LAMP_G;
            end
            HY: begin
                light_highway = LAMP_Y;
            end
            FG: begin
                light_farm = LAMP_G;
                walk       = 1'b1;
            end
            FY: begin
                light_farm = LAMP_Y;
            end
            FLASH: begin
                light_highway = blink ? LAMP_Y : LAMP_D;
                light_farm    = blink ? LAMP_R : LAMP_D;
            end
            default: begin
                light_highway = LAMP_R;
                light_farm    = LAMP_R;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_ctrl_p.sv
// Directed-vector bench for traffic_light_ctrl_p at default parameters.
// Each vector compares {phase, hwy, farm, walk} against hand-derived values.
module tb_traffic_light_ctrl_p;

    logic       clk;
    logic       rst_n;
    logic       car_farm;
    logic       ped_req;
    logic       flash_mode;
    logic [2:0] light_highway;
    logic [2:0] light_farm;
    logic       walk;
    logic [2:0] phase;

    int nvec;
    int nmis;
    int cyc;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] D = 3'b000;

    traffic_light_ctrl_p dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .car_farm     (car_farm),
        .ped_req      (ped_req),
        .flash_mode   (flash_mode),
        .light_highway(light_highway),
        .light_farm   (light_farm),
        .walk         (walk),
        .phase        (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s got %0h expected %0h (cyc %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Never two roads showing green or yellow together
    always @(negedge clk) begin
        if (rst_n) begin
            chk("safety",
                32'((light_highway[1:0] != 2'b00) &&
                    (light_farm[1:0] != 2'b00)),
                32'd0);
        end
    end

    task automatic chk_out(input string tag, input logic [2:0] ph,
                           input logic [2:0] hw, input logic [2:0] fm,
                           input logic wk);
        chk(tag, {22'd0, phase, light_highway, light_farm, walk},
                 {22'd0, ph, hw, fm, wk});
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic at(input int n, input string tag, input logic [2:0] ph,
                      input logic [2:0] hw, input logic [2:0] fm,
                      input logic wk);
        goto(n);
        chk_out(tag, ph, hw, fm, wk);
    endtask

    // Assert reset between clock edges, check async response, release
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_out(tag, 3'd0, G, R, 1'b0);
        chk({tag, "_ped"}, 32'(dut.ped_pending), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        nvec       = 0;
        nmis       = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        car_farm   = 1'b0;
        ped_req    = 1'b0;
        flash_mode = 1'b0;

        // Idle: highway green forever
        do_reset("rst_idle");
        for (int i = 1; i <= 500; i++) begin
            goto(i);
            chk_out("idle", 3'd0, G, R, 1'b0);
        end

        // Car waiting from reset: full farm service
        car_farm = 1'b1;
        do_reset("rst_car");
        at(39,  "car_hg_end",  3'd0, G, R, 1'b0);
        at(40,  "car_hy",      3'd1, Y, R, 1'b0);
        at(51,  "car_hy_end",  3'd1, Y, R, 1'b0);
        at(52,  "car_ar1",     3'd2, R, R, 1'b0);
        at(55,  "car_ar1_end", 3'd2, R, R, 1'b0);
        at(56,  "car_fg",      3'd3, R, G, 1'b1);
        at(95,  "car_fg_end",  3'd3, R, G, 1'b1);
        at(96,  "car_fy",      3'd4, R, Y, 1'b0);
        at(108, "car_ar2",     3'd5, R, R, 1'b0);
        at(111, "car_ar2_end", 3'd5, R, R, 1'b0);
        at(112, "car_hg2",     3'd0, G, R, 1'b0);
        at(151, "car_hg2_min", 3'd0, G, R, 1'b0);
        at(152, "car_hy2",     3'd1, Y, R, 1'b0);

        // Single-cycle pedestrian pulse, no car
        car_farm = 1'b0;
        do_reset("rst_ped");
        goto(5);
        ped_req = 1'b1;
        goto(6);
        ped_req = 1'b0;
        chk("ped_latched", 32'(dut.ped_pending), 32'd1);
        at(39,  "ped_hg_end", 3'd0, G, R, 1'b0);
        at(40,  "ped_hy",     3'd1, Y, R, 1'b0);
        at(56,  "ped_fg",     3'd3, R, G, 1'b1);
        chk("ped_clr", 32'(dut.ped_pending), 32'd0);
        at(112, "ped_hg",     3'd0, G, R, 1'b0);
        at(300, "ped_hold",   3'd0, G, R, 1'b0);

        // Request on the FG-entry cycle loses to the clear
        car_farm = 1'b1;
        do_reset("rst_clr");
        goto(55);
        ped_req = 1'b1;
        goto(56);
        ped_req = 1'b0;
        chk_out("clr_fg", 3'd3, R, G, 1'b1);
        chk("clr_wins", 32'(dut.ped_pending), 32'd0);

        // Flash request during FG, honoured at first HG tick
        do_reset("rst_fl");
        goto(60);
        flash_mode = 1'b1;
        at(96,  "fl_fy",      3'd4, R, Y, 1'b0);
        at(112, "fl_hg",      3'd0, G, R, 1'b0);
        at(115, "fl_hg_end",  3'd0, G, R, 1'b0);
        at(116, "fl_dark",    3'd6, D, D, 1'b0);
        at(119, "fl_dark_e",  3'd6, D, D, 1'b0);
        at(120, "fl_on",      3'd6, Y, R, 1'b0);
        at(124, "fl_dark2",   3'd6, D, D, 1'b0);
        at(128, "fl_on2",     3'd6, Y, R, 1'b0);
        goto(130);
        flash_mode = 1'b0;
        at(131, "fl_on2_end", 3'd6, Y, R, 1'b0);
        at(132, "fl_ar2",     3'd5, R, R, 1'b0);
        at(135, "fl_ar2_end", 3'd5, R, R, 1'b0);
        at(136, "fl_hg2",     3'd0, G, R, 1'b0);
        at(176, "fl_hy2",     3'd1, Y, R, 1'b0);

        // Async reset mid-FG, then timing restarts
        do_reset("rst_mid0");
        at(70, "mid_fg", 3'd3, R, G, 1'b1);
        do_reset("rst_midfg");
        goto(3);
        chk("mid_timer3", 32'(dut.timer), 32'd0);
        goto(4);
        chk("mid_timer4", 32'(dut.timer), 32'd1);
        at(39, "mid_hg_end", 3'd0, G, R, 1'b0);
        at(40, "mid_hy",     3'd1, Y, R, 1'b0);

        // Async reset mid-FLASH with flash still requested
        car_farm   = 1'b0;
        flash_mode = 1'b1;
        do_reset("rst_fl0");
        at(3,  "fl0_hg",    3'd0, G, R, 1'b0);
        at(4,  "fl0_flash", 3'd6, D, D, 1'b0);
        at(10, "fl0_on",    3'd6, Y, R, 1'b0);
        do_reset("rst_midfl");
        at(3,  "fl1_hg",    3'd0, G, R, 1'b0);
        at(4,  "fl1_flash", 3'd6, D, D, 1'b0);
        flash_mode = 1'b0;
        at(8,  "fl1_ar2",   3'd5, R, R, 1'b0);
        at(12, "fl1_hg",    3'd0, G, R, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
